// File: rtl/distance_pkg.sv
// distance_pkg: shared types and defaults for the echo-width distance filter.
// Used by distance_filter and distance_quantize.
package distance_pkg;

    typedef logic [11:0] us_t;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL
    } state_t;

    localparam int BIN_US_DEF = 444;
    localparam int MAX_US_DEF = 3552;

endpackage

// File: rtl/distance_quantize.sv
// distance_quantize: comparator chain mapping an echo width to a 0-7 level.
// Shared with the LED bar logic.
module distance_quantize
    import distance_pkg::*;
#(
    parameter int BIN_US = BIN_US_DEF
) (
    input  us_t        dist_us,
    output logic [2:0] level
);

    always_comb begin
        level = '0;
        for (int k = 1; k <= 7; k++) begin
            if (int'(dist_us) > k * BIN_US) begin
                level = level + 3'd1;
            end
        end
    end

endmodule

// File: rtl/distance_filter.sv
// distance_filter: miss rejection, 4-tap moving average and level quantiser.
// Define DISTANCE_FILTER_HYST_EN to add level hysteresis of HYST_US.
module distance_filter
    import distance_pkg::*;
#(
    parameter int BIN_US     = BIN_US_DEF,
    parameter int MAX_US     = MAX_US_DEF,
    parameter int MISS_LIMIT = 3,
    parameter int HYST_US    = 40
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        meas_valid,
    input  logic [11:0] meas_us,
    input  logic        meas_timeout,
    output logic        dist_valid,
    output logic [11:0] dist_us,
    output logic [2:0]  dist_level,
    output logic        in_range
);

    localparam int MW = $clog2(MISS_LIMIT + 1);

`ifdef DISTANCE_FILTER_HYST_EN
    localparam bit HYST_ON = 1'b1;
`else
    localparam bit HYST_ON = 1'b0;
`endif

    logic          s1_hit;
    logic          s1_miss;
    us_t           s1_us;

    state_t        state;
    logic [2:0]    fill;
    us_t           win [4];
    logic [1:0]    ptr;
    logic [13:0]   sum;
    logic [MW-1:0] miss_cnt;
    logic          s2_upd;
    logic          s2_first;

    us_t           oldest;
    us_t           avg;
    logic [2:0]    raw;
    logic [2:0]    next_level;
    logic          outside;
    int            cur;
    int            lo;
    int            hi;

    assign in_range = (state == FULL);
    assign oldest   = (state == FULL) ? win[ptr] : '0;
    assign avg      = sum[13:2];

    distance_quantize #(
        .BIN_US (BIN_US)
    ) u_quant (
        .dist_us (avg),
        .level   (raw)
    );

    // Keep the current level unless the average leaves its widened bin.
    always_comb begin
        cur = int'(dist_level);
        lo  = cur * BIN_US - HYST_US;
        if (lo < 0) begin
            lo = 0;
        end
        hi  = (cur + 1) * BIN_US + HYST_US;
        outside = (int'(avg) < lo)
               || ((dist_level != 3'd7) && (int'(avg) > hi));
        next_level = (!HYST_ON || s2_first || outside)
                   ? raw : dist_level;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_hit  <= 1'b0;
            s1_miss <= 1'b0;
            s1_us   <= '0;
        end else begin
            s1_hit  <= meas_valid && !meas_timeout
                    && (meas_us <= us_t'(MAX_US));
            s1_miss <= meas_timeout
                    || (meas_valid && (meas_us > us_t'(MAX_US)));
            s1_us   <= meas_us;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= EMPTY;
            fill     <= '0;
            ptr      <= '0;
            sum      <= '0;
            miss_cnt <= '0;
            s2_upd   <= 1'b0;
            s2_first <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                win[i] <= '0;
            end
        end else begin
            s2_upd   <= 1'b0;
            s2_first <= 1'b0;
            unique case (1'b1)
                s1_miss: begin
                    if (miss_cnt == MW'(MISS_LIMIT - 1)) begin
                        state    <= EMPTY;
                        fill     <= '0;
                        ptr      <= '0;
                        sum      <= '0;
                        miss_cnt <= '0;
                        for (int i = 0; i < 4; i++) begin
                            win[i] <= '0;
                        end
                    end else begin
                        miss_cnt <= miss_cnt + 1'b1;
                    end
                end
                s1_hit: begin
                    miss_cnt <= '0;
                    win[ptr] <= s1_us;
                    ptr      <= ptr + 2'd1;
                    sum      <= sum + {2'b00, s1_us} - {2'b00, oldest};
                    case (state)
                        EMPTY: begin
                            state <= FILLING;
                            fill  <= 3'd1;
                        end
                        FILLING: begin
                            fill <= fill + 3'd1;
                            if (fill == 3'd3) begin
                                state    <= FULL;
                                s2_upd   <= 1'b1;
                                s2_first <= 1'b1;
                            end
                        end
                        FULL: begin
                            s2_upd <= 1'b1;
                        end
                        default: begin
                            state <= EMPTY;
                        end
                    endcase
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dist_valid <= 1'b0;
            dist_us    <= '0;
            dist_level <= '0;
        end else begin
            dist_valid <= s2_upd;
            if (s2_upd) begin
                dist_us    <= avg;
                dist_level <= next_level;
            end
        end
    end

endmodule

// File: tb/tb_distance_filter.sv
// tb_distance_filter: scoreboard bench for distance_filter.
// A behavioural window model predicts every dist_valid result.
module tb_distance_filter;

    localparam int BIN  = 444;
    localparam int MAXU = 3552;
    localparam int HYST = 40;

    logic        clk;
    logic        reset_n;
    logic        meas_valid;
    logic [11:0] meas_us;
    logic        meas_timeout;
    logic        dist_valid;
    logic [11:0] dist_us;
    logic [2:0]  dist_level;
    logic        in_range;

    int checks   = 0;
    int failures = 0;
    int nvalid   = 0;
    int exp_us[$];
    int exp_lvl[$];
    int hist[$];
    int miss_n;
    int cur_lvl;
    bit first;

    distance_filter #(
        .BIN_US     (BIN),
        .MAX_US     (MAXU),
        .MISS_LIMIT (3),
        .HYST_US    (HYST)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .meas_valid   (meas_valid),
        .meas_us      (meas_us),
        .meas_timeout (meas_timeout),
        .dist_valid   (dist_valid),
        .dist_us      (dist_us),
        .dist_level   (dist_level),
        .in_range     (in_range)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int qlvl(input int a);
        int l;
        l = 0;
        for (int k = 1; k <= 7; k++) begin
            if (a > k * BIN) l++;
        end
        return l;
    endfunction

    task automatic model_reset();
        hist.delete();
        exp_us.delete();
        exp_lvl.delete();
        miss_n  = 0;
        cur_lvl = 0;
        first   = 1'b1;
    endtask

    task automatic predict();
        int s;
        int avg;
        int raw;
        int lo;
        int hi;
        s = 0;
        foreach (hist[i]) s += hist[i];
        avg = s / 4;
        raw = qlvl(avg);
`ifdef DISTANCE_FILTER_HYST_EN
        lo = cur_lvl * BIN - HYST;
        if (lo < 0) lo = 0;
        hi = (cur_lvl + 1) * BIN + HYST;
        if (first || avg < lo || (cur_lvl != 7 && avg > hi))
            cur_lvl = raw;
`else
        lo = 0;
        hi = 0;
        cur_lvl = raw + lo + hi;
`endif
        first = 1'b0;
        exp_us.push_back(avg);
        exp_lvl.push_back(cur_lvl);
    endtask

    task automatic drive(input bit v, input bit t, input int us);
        @(negedge clk);
        meas_valid   = v;
        meas_timeout = t;
        meas_us      = 12'(us);
        if (t || (v && us > MAXU)) begin
            miss_n++;
            if (miss_n == 3) begin
                hist.delete();
                miss_n = 0;
                first  = 1'b1;
            end
        end else if (v) begin
            miss_n = 0;
            hist.push_back(us);
            if (hist.size() > 4) void'(hist.pop_front());
            if (hist.size() == 4) predict();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            meas_valid   = 1'b0;
            meas_timeout = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && dist_valid) begin
            nvalid++;
            if (exp_us.size() == 0) begin
                chk("spurious_valid", exp_us.size(), 1);
            end else begin
                chk("dist_us", int'(dist_us), exp_us.pop_front());
                chk("dist_level", int'(dist_level), exp_lvl.pop_front());
                chk("in_range_live", int'(in_range), 1);
            end
        end
    end

    initial begin
        int n0;
        reset_n      = 1'b0;
        meas_valid   = 1'b0;
        meas_timeout = 1'b0;
        meas_us      = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_valid", int'(dist_valid), 0);
        chk("rst_us", int'(dist_us), 0);
        chk("rst_level", int'(dist_level), 0);
        chk("rst_in_range", int'(in_range), 0);
        reset_n = 1'b1;

        // First fill: one pulse, two cycles after the 4th hit
        n0 = nvalid;
        repeat (4) drive(1, 0, 1000);
        idle(2);
        chk("t1_early", int'(dist_valid), 0);
        idle(1);
        chk("t1_on_time", int'(dist_valid), 1);
        idle(3);
        chk("t1_count", nvalid - n0, 1);
        chk("t1_in_range", int'(in_range), 1);

        repeat (4) drive(1, 0, 2000);
        idle(4);

        // Sub-limit misses hold outputs; a hit clears the miss count
        drive(1, 0, 4000);
        drive(1, 0, 4000);
        idle(3);
        chk("hold_us", int'(dist_us), 2000);
        chk("hold_level", int'(dist_level), 4);
        chk("hold_in_range", int'(in_range), 1);
        drive(1, 0, 1000);
        drive(1, 0, 4000);
        drive(0, 1, 0);
        idle(3);
        chk("no_flush", int'(in_range), 1);
        repeat (3) drive(0, 1, 0);
        idle(3);
        chk("flush_in_range", int'(in_range), 0);

        // valid with timeout is a miss and leaves the window untouched
        drive(1, 1, 500);
        repeat (3) drive(1, 0, 600);
        idle(3);
        chk("vt_not_full", int'(in_range), 0);
        n0 = nvalid;
        drive(1, 0, 600);
        idle(4);
        chk("vt_one_valid", nvalid - n0, 1);

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 0)
                drive(0, 1, 0);
            else if ($urandom_range(0, 5) == 0)
                idle(1);
            else
                drive(1, 0, $urandom_range(0, 3800));
        end
        idle(5);

        // Async reset with a hit in flight
        repeat (4) drive(1, 0, 800);
        idle(4);
        n0 = nvalid;
        drive(1, 0, 1200);
        idle(1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid", int'(dist_valid), 0);
        chk("arst_us", int'(dist_us), 0);
        chk("arst_level", int'(dist_level), 0);
        chk("arst_in_range", int'(in_range), 0);
        model_reset();
        idle(2);
        reset_n = 1'b1;
        idle(10);
        chk("arst_no_valid", nvalid - n0, 0);

        for (int i = 0; i < 20 && exp_us.size() > 0; i++) idle(1);
        chk("sb_drain", exp_us.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
